srl_fifo32x18: RTL and testbench

- Synchronous FIFO built on a 32-word x 18-bit addressable shift register.
- Writes always shift into tap 0. The read side owns the tap address, which always points at the oldest stored word, and presents that word through a registered first-word-fall-through output stage.
- Used as the elastic buffer between DSP pipeline stages: filter outputs feed it, and the next stage consumes words at its own rate.

---
 rtl/dsp_pkg.sv | 8 +
 rtl/srl_store.sv | 30 +++
 rtl/srl_fifo32x18.sv | 78 +++++++
 tb/tb_srl_fifo32x18.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared defaults for the DSP elastic buffers: word geometry and the tap address width.
package dsp_pkg;
   localparam int WIDTH = 18;
   localparam int DEPTH = 32;
   localparam int AW    = $clog2(DEPTH);

   typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/srl_store.sv
// Addressable shift register: new words enter at tap 0, any tap can be read combinationally.
// No reset on purpose so synthesis maps the array onto SRL primitives.
module srl_store
   import dsp_pkg::*;
#(
   parameter int W  = dsp_pkg::WIDTH,
   parameter int D  = dsp_pkg::DEPTH,
   parameter int A  = $clog2(D)
) (
   input  logic         clk,
   input  logic [W-1:0] d,
   input  logic         sh,
   input  logic [A-1:0] addr,
   output logic [W-1:0] q
);

   logic [W-1:0] mem [D];

   always_ff @(posedge clk) begin
      if (sh) begin
         mem[0] <= d;
         for (int i = 1; i < D; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   assign q = mem[addr];

endmodule

// File: rtl/srl_fifo32x18.sv
// FIFO on an addressable shift register with a registered first-word-fall-through stage.
// The tap address (cnt-1) always points at the oldest word still in the shift register.
module srl_fifo32x18
   import dsp_pkg::*;
#(
   parameter int WIDTH = dsp_pkg::WIDTH,
   parameter int DEPTH = dsp_pkg::DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   input  logic             we,
   output logic             full,
   output logic [WIDTH-1:0] q,
   output logic             qv,
   input  logic             re,
   output logic [AW:0]      lvl,
   output logic             ovf,
   output logic             udf
);

   // Handshake: a write is taken when ce & we & ~full; a read is taken when
   // ce & re & qv. Requests outside those conditions are dropped and only
   // raise the sticky ovf/udf flags.

   logic [AW:0]      cnt;
   logic [AW-1:0]    tap;
   logic [WIDTH-1:0] tap_q;
   logic             push, pop, load;

   assign full = (cnt == (AW+1)'(DEPTH));
   assign lvl  = cnt + {{AW{1'b0}}, qv};
   assign tap  = AW'(cnt - (AW+1)'(1));

   assign push = ce & we & ~full;
   assign pop  = ce & re & qv;
   // Refill the output stage whenever it is empty or being consumed this cycle.
   assign load = ce & (cnt != '0) & (~qv | pop);

   srl_store #(.W(WIDTH), .D(DEPTH), .A(AW)) u_store (
      .clk  (clk),
      .d    (d),
      .sh   (push),
      .addr (tap),
      .q    (tap_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         qv  <= 1'b0;
         q   <= '0;
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         // A simultaneous push and load leave cnt alone: the shift moves the
         // next-oldest word onto the same tap the load just emptied.
         case ({push, load})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase

         if (load) begin
            q  <= tap_q;
            qv <= 1'b1;
         end else if (pop) begin
            qv <= 1'b0;
         end

         if (ce & we & full) ovf <= 1'b1;
         if (ce & re & ~qv)  udf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_srl_fifo32x18.sv
// Bench for srl_fifo32x18: queue-level reference model checked every cycle plus directed literal checks.
module tb_srl_fifo32x18;
   localparam int WIDTH = 18;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ce  = 1'b0;
   logic [WIDTH-1:0] d   = '0;
   logic             we  = 1'b0;
   logic             re  = 1'b0;
   logic             full, qv, ovf, udf;
   logic [WIDTH-1:0] q;
   logic [AW:0]      lvl;

   int errors = 0;
   int checks = 0;

   srl_fifo32x18 dut (
      .clk (clk), .rst (rst), .ce (ce), .d (d), .we (we), .full (full),
      .q (q), .qv (qv), .re (re), .lvl (lvl), .ovf (ovf), .udf (udf)
   );

   // clock/reset block
   always #5 clk = ~clk;

   // reference model: words still in the shift register (oldest first) plus the output stage
   logic [WIDTH-1:0] exp_q[$];
   logic             m_qv  = 1'b0;
   logic [WIDTH-1:0] m_q   = '0;
   logic             m_ovf = 1'b0;
   logic             m_udf = 1'b0;

   always @(posedge clk) begin
      logic m_full, m_push, m_pop, m_load;
      if (rst) begin
         exp_q.delete();
         m_qv = 1'b0; m_q = '0; m_ovf = 1'b0; m_udf = 1'b0;
      end else if (ce) begin
         m_full = (exp_q.size() == DEPTH);
         m_push = we && !m_full;
         m_pop  = re && m_qv;
         m_load = (exp_q.size() != 0) && (!m_qv || m_pop);
         if (we && m_full) m_ovf = 1'b1;
         if (re && !m_qv)  m_udf = 1'b1;
         if (m_load) begin
            m_q  = exp_q.pop_front();
            m_qv = 1'b1;
         end else if (m_pop) begin
            m_qv = 1'b0;
         end
         if (m_push) exp_q.push_back(d);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // compare process: every output, every cycle, against the model
   always @(negedge clk) begin
      chk("m_qv",   32'(qv),   32'(m_qv));
      chk("m_q",    32'(q),    32'(m_q));
      chk("m_lvl",  32'(lvl),  32'(exp_q.size() + int'(m_qv)));
      chk("m_full", 32'(full), 32'(exp_q.size() == DEPTH));
      chk("m_ovf",  32'(ovf),  32'(m_ovf));
      chk("m_udf",  32'(udf),  32'(m_udf));
   end

   // driver: inputs change only just after the falling edge
   task automatic cyc(input logic r_st, input logic c, input logic w, input logic r,
                      input logic [WIDTH-1:0] dd);
      rst = r_st; ce = c; we = w; re = r; d = dd;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int n;
      logic [WIDTH-1:0] first;
      @(negedge clk);
      cyc(1, 0, 0, 0, '0);
      chk("rst_qv", 32'(qv), 0);
      chk("rst_lvl", 32'(lvl), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_q", 32'(q), 0);

      // first-word latency
      cyc(0, 1, 1, 0, 18'h00001);
      chk("lat_qv_e1", 32'(qv), 0);
      cyc(0, 1, 0, 0, '0);
      chk("lat_qv_e2", 32'(qv), 1);
      chk("lat_q", 32'(q), 32'h1);
      chk("lat_lvl", 32'(lvl), 1);
      cyc(0, 1, 0, 1, '0);
      chk("rd_qv", 32'(qv), 0);
      chk("rd_lvl", 32'(lvl), 0);
      chk("rd_udf", 32'(udf), 0);

      // underflow flag
      cyc(1, 0, 0, 0, '0);
      cyc(0, 1, 0, 1, '0);
      chk("udf_set", 32'(udf), 1);
      chk("udf_qv", 32'(qv), 0);
      chk("udf_lvl", 32'(lvl), 0);

      // fill to capacity, overflow, drain
      for (int i = 0; i < 33; i++) cyc(0, 1, 1, 0, WIDTH'(i));
      chk("fill_full", 32'(full), 1);
      chk("fill_lvl", 32'(lvl), 33);
      cyc(0, 1, 1, 0, 18'h3FFFF);
      chk("ovf_set", 32'(ovf), 1);
      chk("ovf_lvl", 32'(lvl), 33);
      n = 0;
      for (int k = 0; k < 40 && qv; k++) begin
         chk("drain_q", 32'(q), 32'(n));
         n++;
         cyc(0, 1, 0, 1, '0);
      end
      chk("drain_cnt", 32'(n), 33);
      chk("udf_sticky", 32'(udf), 1);

      // steady state with 5 preloaded
      cyc(1, 0, 0, 0, '0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, WIDTH'(18'h100 + i));
      chk("pre_lvl", 32'(lvl), 5);
      for (int i = 0; i < 100; i++) cyc(0, 1, 1, 1, WIDTH'($urandom_range(0, 18'h3FFFF)));
      chk("ss_lvl", 32'(lvl), 5);
      chk("ss_ovf", 32'(ovf), 0);
      chk("ss_udf", 32'(udf), 0);

      // clock enable hold
      cyc(1, 0, 0, 0, '0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, WIDTH'(18'h200 + i));
      first = 18'h200;
      for (int i = 0; i < 10; i++)
         cyc(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom()));
      chk("ce_lvl", 32'(lvl), 3);
      chk("ce_qv", 32'(qv), 1);
      chk("ce_q", 32'(q), 32'(first));
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, '0);

      // mid-stream reset
      cyc(1, 0, 0, 0, '0);
      for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0, WIDTH'(18'h300 + i));
      chk("pre_rst_lvl", 32'(lvl), 20);
      cyc(1, 1, 0, 0, '0);
      chk("mrst_qv", 32'(qv), 0);
      chk("mrst_lvl", 32'(lvl), 0);
      chk("mrst_full", 32'(full), 0);
      chk("mrst_ovf", 32'(ovf), 0);
      chk("mrst_udf", 32'(udf), 0);
      cyc(0, 1, 1, 0, 18'h2AAAA);
      cyc(0, 1, 0, 0, '0);
      chk("post_q", 32'(q), 32'h2AAAA);
      chk("post_qv", 32'(qv), 1);

      // random traffic against the model
      for (int i = 0; i < 3000; i++)
         cyc(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 7) != 0),
             1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
             WIDTH'($urandom()));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
